// File: rtl/msrh_cmt_collector_pkg.sv
// msrh_cmt_collector_pkg: shared sizes and bus types for the in-order completion tracker
package msrh_cmt_collector_pkg;
    localparam int ENTRY_SIZE = 16;
    localparam int DISP_SIZE  = 4;
    localparam int DONE_PORTS = 4;
    localparam int IDX_W      = $clog2(ENTRY_SIZE);
    localparam int CMT_ID_W   = IDX_W + 1;
    typedef logic [CMT_ID_W-1:0]  cmt_id_t;
    typedef logic [DISP_SIZE-1:0] grp_t;
    typedef struct packed {
        cmt_id_t cmt_id;
        grp_t    grp_id;
        logic    flush;
    } commit_blk_t;
    typedef struct packed {
        logic    valid;
        cmt_id_t cmt_id;
        grp_t    grp_id;
        logic    except;
    } done_rpt_t;
    function automatic logic [IDX_W-1:0] idx_of(cmt_id_t id);
        return id[IDX_W-1:0];
    endfunction
    function automatic logic wrap_of(cmt_id_t id);
        return id[CMT_ID_W-1];
    endfunction
endpackage

// File: rtl/msrh_cmt_collector_if.sv
// msrh_cmt_collector_if: dispatch, done-report and commit signals of the completion tracker
interface msrh_cmt_collector_if;
    import msrh_cmt_collector_pkg::*;
    logic                        disp_fire;
    grp_t                        disp_valid;
    logic                        disp_ready;
    cmt_id_t                     disp_cmt_id;
    done_rpt_t [DONE_PORTS-1:0]  done;
    logic                        commit_valid;
    commit_blk_t                 commit;
    logic                        empty;
    modport master (
        output disp_fire, disp_valid, done,
        input  disp_ready, disp_cmt_id, commit_valid, commit, empty
    );
    modport slave (
        input  disp_fire, disp_valid, done,
        output disp_ready, disp_cmt_id, commit_valid, commit, empty
    );
endinterface

// File: rtl/msrh_cmt_collector_wrap_ptr.sv
// msrh_cmt_collector_wrap_ptr: wrap-bit pointer with increment and load, load winning
module msrh_cmt_collector_wrap_ptr
    import msrh_cmt_collector_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    inc,
    input  logic    load,
    input  cmt_id_t load_val,
    output cmt_id_t ptr
);
    always_ff @(posedge clk)
        ptr <= rst ? '0 : load ? load_val : inc ? cmt_id_t'(ptr + 1'b1) : ptr;
endmodule

// File: rtl/msrh_cmt_collector.sv
// msrh_cmt_collector: gathers per-lane done reports and retires dispatch groups in age order
module msrh_cmt_collector
    import msrh_cmt_collector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    msrh_cmt_collector_if.slave bus
);
    cmt_id_t                        head, tail;
    logic [IDX_W-1:0]               hidx, tidx, pidx;
    logic [ENTRY_SIZE-1:0]          e_valid, e_wrap, e_exc;
    grp_t [ENTRY_SIZE-1:0]          e_lanes, e_done, done_set;
    logic [ENTRY_SIZE-1:0]          exc_set, alloc, retire;
    logic [DONE_PORTS-1:0]          hit;
    logic                           full, head_cpl, flush_now, disp_en;

    always_comb begin
        hidx      = idx_of(head);
        tidx      = idx_of(tail);
        full      = (hidx == tidx) && (wrap_of(head) != wrap_of(tail));
        head_cpl  = e_valid[hidx] && (e_done[hidx] == e_lanes[hidx]);
        flush_now = head_cpl && e_exc[hidx];
        disp_en   = bus.disp_fire && bus.disp_ready;
    end

    assign bus.disp_ready  = !full && !flush_now;
    assign bus.disp_cmt_id = tail;
    assign bus.empty       = head == tail;

    // Reports are merged per entry first so several ports hitting one group OR together.
    always_comb begin
        alloc    = '0;
        retire   = '0;
        done_set = '0;
        exc_set  = '0;
        hit      = '0;
        pidx     = '0;
        alloc[tidx]  = disp_en;
        retire[hidx] = head_cpl;
        for (int p = 0; p < DONE_PORTS; p++) begin
            pidx   = idx_of(bus.done[p].cmt_id);
            hit[p] = bus.done[p].valid && e_valid[pidx] && !flush_now &&
                     (e_wrap[pidx] == wrap_of(bus.done[p].cmt_id)) &&
                     |(bus.done[p].grp_id & e_lanes[pidx]);
            if (hit[p]) begin
                done_set[pidx] = done_set[pidx] | (bus.done[p].grp_id & e_lanes[pidx]);
                exc_set[pidx]  = exc_set[pidx] | bus.done[p].except;
            end
        end
    end

    msrh_cmt_collector_wrap_ptr u_head (
        .clk(clk), .rst(rst), .inc(head_cpl), .load(1'b0), .load_val('0), .ptr(head)
    );
    msrh_cmt_collector_wrap_ptr u_tail (
        .clk(clk), .rst(rst), .inc(disp_en), .load(flush_now),
        .load_val(cmt_id_t'(head + 1'b1)), .ptr(tail)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= '0;
            e_wrap  <= '0;
            e_exc   <= '0;
            e_lanes <= '0;
            e_done  <= '0;
        end else begin
            e_valid <= alloc | (e_valid & ~retire & {ENTRY_SIZE{!flush_now}});
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                e_wrap[i]  <= alloc[i] ? wrap_of(tail) : e_wrap[i];
                e_lanes[i] <= alloc[i] ? bus.disp_valid : e_lanes[i];
                e_done[i]  <= alloc[i] ? '0 : e_done[i] | done_set[i];
                e_exc[i]   <= alloc[i] ? 1'b0 : e_exc[i] | exc_set[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.commit_valid <= 1'b0;
            bus.commit       <= '0;
        end else begin
            bus.commit_valid <= head_cpl;
            bus.commit       <= head_cpl ? '{cmt_id: head, grp_id: e_lanes[hidx], flush: flush_now} : '0;
        end
    end

    a_disp_nonempty: assert property (@(posedge clk) disable iff (rst) bus.disp_fire |-> |bus.disp_valid)
        else $error("dispatch fired with an empty lane mask");
endmodule

// File: tb/tb_msrh_cmt_collector.sv
// tb_msrh_cmt_collector: queue-based reference model, directed scenarios and random traffic
module tb_msrh_cmt_collector;
    import msrh_cmt_collector_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    msrh_cmt_collector_if bus();
    msrh_cmt_collector dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        cmt_id_t id;
        grp_t    lanes;
        grp_t    done;
        logic    exc;
    } grp_s;

    grp_s    q[$];
    cmt_id_t tail_id;
    logic    ec_v, ec_fl;
    cmt_id_t ec_id;
    grp_t    ec_grp;
    int      n_chk, n_pass, commits, c0;
    bit      started;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit m_cpl();
        return q.size() > 0 && q[0].done == q[0].lanes;
    endfunction
    function automatic bit m_flush();
        return m_cpl() && q[0].exc;
    endfunction
    function automatic bit m_ready();
        return q.size() < ENTRY_SIZE && !m_flush();
    endfunction

    // Groups live in age order in a queue; ids are matched in full, so stale wraps never match.
    task automatic model_step();
        bit   cpl, fl, rdy;
        grp_s g;
        cpl = m_cpl();
        fl  = m_flush();
        rdy = m_ready();
        if (!fl)
            for (int p = 0; p < DONE_PORTS; p++)
                if (bus.done[p].valid)
                    for (int i = 0; i < q.size(); i++)
                        if (q[i].id == bus.done[p].cmt_id && (q[i].lanes & bus.done[p].grp_id) != 0) begin
                            g = q[i];
                            g.done = g.done | (bus.done[p].grp_id & g.lanes);
                            g.exc  = g.exc | bus.done[p].except;
                            q[i] = g;
                        end
        ec_v = cpl;
        if (cpl) begin
            g = q.pop_front();
            ec_id  = g.id;
            ec_grp = g.lanes;
            ec_fl  = fl;
            if (fl) begin
                q.delete();
                tail_id = g.id + 1'b1;
            end
        end
        if (bus.disp_fire && rdy) begin
            g = '{id: tail_id, lanes: bus.disp_valid, done: '0, exc: 1'b0};
            q.push_back(g);
            tail_id = tail_id + 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            q.delete();
            tail_id = '0;
            ec_v = 1'b0; ec_fl = 1'b0; ec_id = '0; ec_grp = '0;
            started = 1'b1;
        end else model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("disp_ready", bus.disp_ready, m_ready());
            chk("disp_cmt_id", bus.disp_cmt_id, tail_id);
            chk("empty", bus.empty, q.size() == 0);
            chk("commit_valid", bus.commit_valid, ec_v);
            if (ec_v) begin
                chk("commit_cmt_id", bus.commit.cmt_id, ec_id);
                chk("commit_grp_id", bus.commit.grp_id, ec_grp);
                chk("commit_flush", bus.commit.flush, ec_fl);
            end
            if (bus.commit_valid) commits++;
        end
    end

    task automatic clr();
        bus.disp_fire  = 1'b0;
        bus.disp_valid = '0;
        bus.done       = '0;
    endtask
    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        clr();
        tick(2);
        rst = 1'b0;
    endtask
    task automatic disp(grp_t v);
        bus.disp_fire  = 1'b1;
        bus.disp_valid = v;
    endtask
    task automatic done_on(int p, cmt_id_t id, int lane, logic ex);
        bus.done[p] = '{valid: 1'b1, cmt_id: id, grp_id: grp_t'(1 << lane), except: ex};
    endtask

    initial begin
        clr();
        tick(2);
        rst = 1'b0;
        // single two-lane group completed by two ports in one cycle
        chk("t1 first id", bus.disp_cmt_id, 0);
        disp(4'b0011); tick(); clr();
        done_on(0, 5'h00, 0, 1'b0); done_on(1, 5'h00, 1, 1'b0); tick(); clr(); tick();
        chk("t1 commit_valid", bus.commit_valid, 1);
        chk("t1 commit_id", bus.commit.cmt_id, 0);
        chk("t1 commit_grp", bus.commit.grp_id, 4'b0011);
        chk("t1 commit_flush", bus.commit.flush, 0);
        chk("t1 empty", bus.empty, 1);
        // out-of-order completion, in-order retire
        do_reset();
        disp(4'b0001); tick(); disp(4'b0011); tick(); disp(4'b1111); tick(); clr();
        for (int l = 0; l < 4; l++) done_on(l, 5'h02, l, 1'b0);
        tick(); clr();
        done_on(0, 5'h01, 0, 1'b0); done_on(1, 5'h01, 1, 1'b0); tick(); clr();
        done_on(0, 5'h00, 0, 1'b0); tick(); clr();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2 commit_valid", bus.commit_valid, 1);
            chk("t2 commit_id", bus.commit.cmt_id, k);
        end
        // full tracker, held dispatch, wrap and stale report
        do_reset();
        repeat (ENTRY_SIZE) begin disp(4'b0001); tick(); end
        clr();
        chk("t3 full ready", bus.disp_ready, 0);
        done_on(0, 5'h00, 0, 1'b0); disp(4'b0001); tick();
        bus.done = '0;
        chk("t3 still full", bus.disp_ready, 0);
        tick();
        chk("t3 ready after retire", bus.disp_ready, 1);
        chk("t3 wrapped id", bus.disp_cmt_id, 5'h10);
        tick(); clr();
        chk("t3 next id", bus.disp_cmt_id, 5'h11);
        done_on(0, 5'h00, 0, 1'b0); tick(); clr(); tick(2);
        chk("t3 stale ignored", bus.commit_valid, 0);
        // exception flush
        do_reset();
        repeat (4) begin disp(4'b0001); tick(); end
        clr();
        done_on(0, 5'h00, 0, 1'b0); tick(); clr();
        done_on(0, 5'h01, 0, 1'b1); tick(); clr();
        chk("t4 flush blocks ready", bus.disp_ready, 0);
        chk("t4 commit0", bus.commit.cmt_id, 0);
        disp(4'b0001); tick();
        chk("t4 flush commit", bus.commit_valid, 1);
        chk("t4 flush id", bus.commit.cmt_id, 1);
        chk("t4 flush bit", bus.commit.flush, 1);
        chk("t4 id after flush", bus.disp_cmt_id, 2);
        tick(); clr();
        chk("t4 id after redispatch", bus.disp_cmt_id, 3);
        // redundant and duplicate reports
        do_reset();
        disp(4'b0011); tick(); clr();
        done_on(0, 5'h00, 0, 1'b0); done_on(1, 5'h00, 0, 1'b0); done_on(2, 5'h00, 1, 1'b0);
        c0 = commits;
        tick(); clr();
        done_on(0, 5'h00, 0, 1'b0); tick(); clr(); tick(3);
        chk("t5 single commit", commits - c0, 1);
        // reset in mid-operation
        do_reset();
        repeat (5) begin disp(4'b1111); tick(); end
        clr();
        done_on(0, 5'h00, 0, 1'b0); done_on(1, 5'h01, 1, 1'b0); done_on(2, 5'h02, 2, 1'b0);
        tick(); clr();
        rst = 1'b1;
        done_on(3, 5'h03, 3, 1'b0);
        tick();
        chk("t6 empty", bus.empty, 1);
        chk("t6 ready", bus.disp_ready, 1);
        chk("t6 no commit", bus.commit_valid, 0);
        chk("t6 id", bus.disp_cmt_id, 0);
        rst = 1'b0; clr();
        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            clr();
            if ($urandom_range(0, 999) == 0) rst = 1'b1;
            else rst = 1'b0;
            if ($urandom_range(0, 2) != 0) disp(grp_t'($urandom_range(1, 15)));
            for (int p = 0; p < DONE_PORTS; p++) begin
                if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    int i;
                    i = $urandom_range(0, q.size() - 1);
                    done_on(p, q[i].id, $urandom_range(0, 3), $urandom_range(0, 24) == 0);
                end else if ($urandom_range(0, 7) == 0)
                    done_on(p, cmt_id_t'($urandom), $urandom_range(0, 3), 1'b0);
            end
            tick();
        end
        rst = 1'b0; clr(); tick(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
